// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared FSM states, key codes and keypad geometry for the scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_NONE = 4'h0;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_ZERO = 4'hB;
  localparam logic [3:0] KEY_HASH = 4'hC;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  // Layout gives row*3 + col + 1, so '*', '0', '#' fall out as A, B, C.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_if
// Brief    : Keypad matrix lines plus the key/key_valid output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] col_n;
  logic [NUM_ROWS-1:0] row_n;
  logic [3:0]          key;
  logic                key_valid;

  modport master (input col_n, output row_n, output key, output key_valid);
  modport slave  (output col_n, input row_n, input key, input key_valid);

endinterface
`default_nettype wire

// File: rtl/keypad_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : keypad_tick_gen
// Brief    : Divides clk by SCAN_DIV into a one-cycle scan tick.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int             c_cnt_w = $clog2(SCAN_DIV);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SCAN_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x3 keypad row scanner with debounce and key encoding.
//            Define KEYPAD_REPEAT_EN for auto-repeat while a key is held.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_PERIOD  = 25
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  bus
);

  localparam int                c_db_w    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_TICKS - 1);

  logic [NUM_COLS-1:0] r_sync1, r_sync2;
  logic                w_tick;
  state_t              r_state, w_state_nxt;
  logic [1:0]          r_row, w_row_nxt;
  logic [1:0]          r_key_col, w_key_col_nxt;
  logic [c_db_w-1:0]   r_db_cnt, w_db_cnt_nxt;
  logic [c_db_w-1:0]   r_rel_cnt, w_rel_cnt_nxt;
  logic [3:0]          r_key, w_key_nxt;
  logic                r_key_valid, w_key_valid_nxt;
  logic                w_all_high, w_one_low;
  logic [1:0]          w_low_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_rpt_w   = $clog2(c_rpt_max + 1);
  localparam logic [c_rpt_w-1:0] c_delay_last  = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_period_last = c_rpt_w'(REPEAT_PERIOD - 1);

  logic [c_rpt_w-1:0] r_rpt_cnt, w_rpt_cnt_nxt;
  logic               r_rpt_armed, w_rpt_armed_nxt;
  logic [c_rpt_w-1:0] w_rpt_limit;

  assign w_rpt_limit = r_rpt_armed ? c_period_last : c_delay_last;
`endif

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.col_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_all_high = &r_sync2;

  always_comb begin
    w_one_low = 1'b1;
    w_low_idx = 2'd0;
    case (r_sync2)
      3'b110:  w_low_idx = 2'd0;
      3'b101:  w_low_idx = 2'd1;
      3'b011:  w_low_idx = 2'd2;
      default: w_one_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_row       <= 2'd0;
      r_key_col   <= 2'd0;
      r_db_cnt    <= '0;
      r_rel_cnt   <= '0;
      r_key       <= KEY_NONE;
      r_key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_key_col   <= w_key_col_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_rel_cnt   <= w_rel_cnt_nxt;
      r_key       <= w_key_nxt;
      r_key_valid <= w_key_valid_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rpt_cnt   <= w_rpt_cnt_nxt;
      r_rpt_armed <= w_rpt_armed_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_key_col_nxt   = r_key_col;
    w_db_cnt_nxt    = r_db_cnt;
    w_rel_cnt_nxt   = r_rel_cnt;
    w_key_nxt       = r_key;
    w_key_valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rpt_cnt_nxt   = r_rpt_cnt;
    w_rpt_armed_nxt = r_rpt_armed;
`endif
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_one_low) begin
            w_key_col_nxt = w_low_idx;
            w_db_cnt_nxt  = '0;
            w_state_nxt   = DEBOUNCE;
          end else begin
            // Idle or ghosting pattern: keep scanning.
            w_row_nxt = r_row + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (w_one_low && (w_low_idx == r_key_col)) begin
            if (r_db_cnt == c_db_last) begin
              w_key_nxt       = key_code(r_row, r_key_col);
              w_key_valid_nxt = 1'b1;
              w_rel_cnt_nxt   = '0;
              w_state_nxt     = HELD;
`ifdef KEYPAD_REPEAT_EN
              w_rpt_cnt_nxt   = '0;
              w_rpt_armed_nxt = 1'b0;
`endif
            end else begin
              w_db_cnt_nxt = r_db_cnt + 1'b1;
            end
          end else begin
            w_state_nxt = SCAN;
            w_row_nxt   = r_row + 2'd1;
          end
        end
        HELD: begin
          if (w_all_high) begin
            if (r_rel_cnt == c_db_last) begin
              w_state_nxt = SCAN;
              w_row_nxt   = r_row + 2'd1;
            end else begin
              w_rel_cnt_nxt = r_rel_cnt + 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            w_rpt_cnt_nxt   = '0;
            w_rpt_armed_nxt = 1'b0;
`endif
          end else begin
            w_rel_cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
            if (r_rpt_cnt == w_rpt_limit) begin
              w_key_valid_nxt = 1'b1;
              w_rpt_cnt_nxt   = '0;
              w_rpt_armed_nxt = 1'b1;
            end else begin
              w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
            end
`endif
          end
        end
        default: w_state_nxt = SCAN;
      endcase
    end
  end

  assign bus.row_n     = ~(4'b0001 << r_row);
  assign bus.key       = r_key;
  assign bus.key_valid = r_key_valid;

endmodule
`default_nettype wire
